uart_byte_rx: RTL and testbench



---
 rtl/uart_pkg.sv | 31 +++
 rtl/uart_baud_tick.sv | 33 +++
 rtl/uart_byte_rx.sv | 131 +++++++++++++
 tb/tb_uart_byte_rx.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: baud-select encodings, divider helper, receiver FSM states.
package uart_pkg;

  localparam logic [2:0] BAUD_9600   = 3'd0;
  localparam logic [2:0] BAUD_19200  = 3'd1;
  localparam logic [2:0] BAUD_38400  = 3'd2;
  localparam logic [2:0] BAUD_57600  = 3'd3;
  localparam logic [2:0] BAUD_115200 = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } rx_state_e;

  // Oversample divider: round(clk_freq / (16 * baud)) - 1; unknown selects fall back to 9600.
  function automatic logic [8:0] baud_div(input int unsigned clk_freq, input logic [2:0] sel);
    int unsigned baud;
    case (sel)
      BAUD_19200:  baud = 19200;
      BAUD_38400:  baud = 38400;
      BAUD_57600:  baud = 57600;
      BAUD_115200: baud = 115200;
      default:     baud = 9600;
    endcase
    return 9'((clk_freq + 8 * baud) / (16 * baud) - 1);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// 16x oversample tick generator: 9-bit clock divider feeding a 4-bit tick counter.
module uart_baud_tick (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       clr,
  input  logic [8:0] div,
  output logic       os_tick,
  output logic [3:0] tick
);

  logic [8:0] div_cnt;

  assign os_tick = en && (div_cnt == div);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      tick    <= '0;
    end else if (clr) begin
      div_cnt <= '0;
      tick    <= '0;
    end else if (en) begin
      if (os_tick) begin
        div_cnt <= '0;
        tick    <= tick + 4'd1;
      end else begin
        div_cnt <= div_cnt + 9'd1;
      end
    end
  end

endmodule

// File: rtl/uart_byte_rx.sv
// 8N1 UART byte receiver with 16x oversampling and start/stop validation.
// Define UART_RX_MAJORITY_EN to decide each bit by 2-of-3 vote over ticks 7, 8, 9.
module uart_byte_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 50_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] baud_set,
  input  logic       rs232_rx,
  output logic [7:0] data,
  output logic       rx_done,
  output logic       frame_err,
  output logic       uart_state
);

  logic       sync1, sync2, sync3;
  logic       fall;
  rx_state_e  state;
  logic [2:0] baud_q;
  logic [2:0] bit_idx;
  logic [7:0] shreg;
  logic [8:0] div_sel;
  logic       os_tick;
  logic [3:0] tick;
  logic       cnt_clr;
  logic       bnd;
  logic       smp_evt;
  logic       smp_bit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) {sync1, sync2, sync3} <= 3'b111;
    else        {sync1, sync2, sync3} <= {rs232_rx, sync1, sync2};
  end

  assign fall = !sync2 && sync3;

  // Constant arguments per arm so each divider value folds to a literal.
  always_comb begin
    div_sel = baud_div(CLK_FREQ, BAUD_9600);
    case (baud_q)
      BAUD_19200:  div_sel = baud_div(CLK_FREQ, BAUD_19200);
      BAUD_38400:  div_sel = baud_div(CLK_FREQ, BAUD_38400);
      BAUD_57600:  div_sel = baud_div(CLK_FREQ, BAUD_57600);
      BAUD_115200: div_sel = baud_div(CLK_FREQ, BAUD_115200);
      default:     div_sel = baud_div(CLK_FREQ, BAUD_9600);
    endcase
  end

  assign cnt_clr = (state == ST_IDLE) || (state == ST_BREAK);

  uart_baud_tick u_tick (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (!cnt_clr),
    .clr     (cnt_clr),
    .div     (div_sel),
    .os_tick (os_tick),
    .tick    (tick)
  );

  // "Tick N" is the os_tick that advances the count to N; 15->0 is the bit boundary.
  assign bnd = os_tick && (tick == 4'd15);

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] smp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                        smp <= 2'b11;
    else if (os_tick && (tick == 4'd6 || tick == 4'd7)) smp <= {smp[0], sync2};
  end

  assign smp_evt = os_tick && (tick == 4'd8);
  assign smp_bit = (smp[1] & smp[0]) | (smp[1] & sync2) | (smp[0] & sync2);
`else
  assign smp_evt = os_tick && (tick == 4'd7);
  assign smp_bit = sync2;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      baud_q    <= BAUD_9600;
      bit_idx   <= '0;
      shreg     <= '0;
      data      <= '0;
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        ST_IDLE: if (fall) begin
          state  <= ST_START;
          baud_q <= baud_set;
        end
        ST_START: begin
          if (smp_evt && smp_bit) state <= ST_IDLE;
          else if (bnd) begin
            state   <= ST_DATA;
            bit_idx <= '0;
          end
        end
        ST_DATA: begin
          if (smp_evt) shreg <= {smp_bit, shreg[7:1]};
          if (bnd) begin
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= ST_STOP;
          end
        end
        // Leaving at mid-stop lets a start edge half a bit later be caught.
        ST_STOP: if (smp_evt) begin
          if (smp_bit) begin
            data    <= shreg;
            rx_done <= 1'b1;
            state   <= ST_IDLE;
          end else begin
            frame_err <= 1'b1;
            state     <= ST_BREAK;
          end
        end
        ST_BREAK: if (sync2) state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  assign uart_state = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_byte_rx.sv
// Self-checking bench for uart_byte_rx: serial frames driven behaviourally, received bytes scoreboarded.
module tb_uart_byte_rx;

  localparam int CLK_FREQ = 12_500_000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] baud_set = 3'd4;
  logic       rs232_rx = 1'b1;
  logic [7:0] data;
  logic       rx_done, frame_err, uart_state;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_byte_rx #(.CLK_FREQ(CLK_FREQ)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .baud_set   (baud_set),
    .rs232_rx   (rs232_rx),
    .data       (data),
    .rx_done    (rx_done),
    .frame_err  (frame_err),
    .uart_state (uart_state)
  );

  // Monitor: records every completion with its cycle stamp and pulse-shape anomalies.
  int         rx_cnt = 0, fe_cnt = 0, hi_cnt = 0, overlap = 0, wide = 0;
  logic [7:0] got_q[$];
  int         stamp_q[$];
  logic       rx_prev = 1'b0, fe_prev = 1'b0;

  always @(negedge clk) begin
    if (rx_done) begin
      got_q.push_back(data);
      stamp_q.push_back(cyc);
      rx_cnt <= rx_cnt + 1;
    end
    if (frame_err)             fe_cnt  <= fe_cnt + 1;
    if (uart_state)            hi_cnt  <= hi_cnt + 1;
    if (rx_done && frame_err)  overlap <= overlap + 1;
    if ((rx_done && rx_prev) || (frame_err && fe_prev)) wide <= wide + 1;
    rx_prev <= rx_done;
    fe_prev <= frame_err;
  end

  // Clocks per bit from the nominal baud rate, rounded to a whole oversample period.
  function automatic int bit_clks(input logic [2:0] sel);
    real baud;
    case (sel)
      3'd1:    baud = 19200.0;
      3'd2:    baud = 38400.0;
      3'd3:    baud = 57600.0;
      3'd4:    baud = 115200.0;
      default: baud = 9600.0;
    endcase
    return 16 * $rtoi(CLK_FREQ / (16.0 * baud) + 0.5);
  endfunction

  task automatic drive_bit(input logic v, input int n);
    rs232_rx = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input int bc, input logic stop);
    drive_bit(1'b0, bc);
    for (int i = 0; i < 8; i++) drive_bit(b[i], bc);
    drive_bit(stop, bc);
  endtask

  task automatic wait_rx(input int target, input int budget);
    int n;
    n = 0;
    while (rx_cnt < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset;
    int h0;
    rst_n = 1'b0;
    rs232_rx = 1'b1;
    repeat (20) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    tests++; if (data !== 8'h00) begin fails++; $display("FAIL reset_data got %h want 00", data); end
    tests++; if (rx_done !== 1'b0) begin fails++; $display("FAIL reset_rx_done got %b want 0", rx_done); end
    tests++; if (frame_err !== 1'b0) begin fails++; $display("FAIL reset_frame_err got %b want 0", frame_err); end
    tests++; if (uart_state !== 1'b0) begin fails++; $display("FAIL reset_uart_state got %b want 0", uart_state); end
    h0 = hi_cnt;
    repeat (1000) @(negedge clk);
    tests++; if (hi_cnt - h0 !== 0) begin fails++; $display("FAIL idle_state high for %0d clk want 0", hi_cnt - h0); end
  endtask

  task automatic test_loopback;
    int bc, n0, f0, t0, lat, exp_lat;
    baud_set = 3'd4;
    bc = bit_clks(3'd4);
    n0 = rx_cnt; f0 = fe_cnt;
    t0 = cyc;
    send_frame(8'hAA, bc, 1'b1);
    repeat (5000) @(negedge clk);
    send_frame(8'h55, bc, 1'b1);
    wait_rx(n0 + 2, 2 * bc);
    tests++; if (rx_cnt - n0 !== 2) begin fails++; $display("FAIL loop_count got %0d want 2", rx_cnt - n0); end
    tests++; if (got_q.size() < n0 + 1 || got_q[n0] !== 8'hAA) begin fails++; $display("FAIL loop_byte0 got %h want aa", got_q.size() > n0 ? got_q[n0] : 8'hxx); end
    tests++; if (got_q.size() < n0 + 2 || got_q[n0+1] !== 8'h55) begin fails++; $display("FAIL loop_byte1 got %h want 55", got_q.size() > n0 + 1 ? got_q[n0+1] : 8'hxx); end
    lat = (stamp_q.size() > n0) ? stamp_q[n0] - t0 : -1;
    exp_lat = (19 * bc) / 2 + 4;
    tests++; if (lat < exp_lat - 16 || lat > exp_lat + 16) begin fails++; $display("FAIL loop_latency got %0d want %0d+-16", lat, exp_lat); end
    tests++; if (fe_cnt - f0 !== 0) begin fails++; $display("FAIL loop_frame_err got %0d pulses want 0", fe_cnt - f0); end
  endtask

  task automatic test_glitch;
    int bc, n0, f0, h0, hi;
    logic [7:0] d0;
    baud_set = 3'd4;
    bc = bit_clks(3'd4);
    d0 = data; n0 = rx_cnt; f0 = fe_cnt; h0 = hi_cnt;
    drive_bit(1'b0, 5);
    drive_bit(1'b1, 2 * bc);
    hi = hi_cnt - h0;
    tests++; if (hi < 1 || hi > bc / 2 + bc / 16 + 4) begin fails++; $display("FAIL glitch_state_cycles got %0d want 1..%0d", hi, bc / 2 + bc / 16 + 4); end
    tests++; if (uart_state !== 1'b0) begin fails++; $display("FAIL glitch_state_end got %b want 0", uart_state); end
    tests++; if (rx_cnt - n0 !== 0 || fe_cnt - f0 !== 0) begin fails++; $display("FAIL glitch_pulses got rx %0d fe %0d want 0 0", rx_cnt - n0, fe_cnt - f0); end
    tests++; if (data !== d0) begin fails++; $display("FAIL glitch_data got %h want %h", data, d0); end
  endtask

  task automatic test_frame_err;
    int bc, n0, f0;
    logic [7:0] d0;
    baud_set = 3'd0;
    bc = bit_clks(3'd0);
    d0 = data; n0 = rx_cnt; f0 = fe_cnt;
    drive_bit(1'b0, bc);
    for (int i = 0; i < 8; i++) drive_bit(1'(8'h3C >> i), bc);
    drive_bit(1'b0, 3 * bc);
    tests++; if (uart_state !== 1'b1) begin fails++; $display("FAIL ferr_state_held got %b want 1", uart_state); end
    tests++; if (fe_cnt - f0 !== 1) begin fails++; $display("FAIL ferr_pulses got %0d want 1", fe_cnt - f0); end
    tests++; if (rx_cnt - n0 !== 0) begin fails++; $display("FAIL ferr_rx_done got %0d want 0", rx_cnt - n0); end
    tests++; if (data !== d0) begin fails++; $display("FAIL ferr_data got %h want %h", data, d0); end
    drive_bit(1'b1, 4);
    tests++; if (uart_state !== 1'b0) begin fails++; $display("FAIL ferr_release got %b want 0", uart_state); end
    drive_bit(1'b1, bc);
    baud_set = 3'd4;
    bc = bit_clks(3'd4);
    send_frame(8'h81, bc, 1'b1);
    wait_rx(n0 + 1, 2 * bc);
    tests++; if (data !== 8'h81 || rx_cnt - n0 !== 1) begin fails++; $display("FAIL ferr_recover got %h/%0d want 81/1", data, rx_cnt - n0); end
  endtask

  task automatic test_back_to_back;
    int bc, n0, gap;
    baud_set = 3'd2;
    bc = bit_clks(3'd2);
    n0 = rx_cnt;
    send_frame(8'h00, bc, 1'b1);
    send_frame(8'hFF, bc, 1'b1);
    wait_rx(n0 + 2, 2 * bc);
    tests++; if (rx_cnt - n0 !== 2) begin fails++; $display("FAIL b2b_count got %0d want 2", rx_cnt - n0); end
    tests++; if (got_q.size() < n0 + 2 || got_q[n0] !== 8'h00 || got_q[n0+1] !== 8'hFF) begin fails++; $display("FAIL b2b_bytes got %h %h want 00 ff", got_q.size() > n0 ? got_q[n0] : 8'hxx, got_q.size() > n0 + 1 ? got_q[n0+1] : 8'hxx); end
    gap = (stamp_q.size() >= n0 + 2) ? stamp_q[n0+1] - stamp_q[n0] : -1;
    tests++; if (gap < 10 * bc - bc / 16 || gap > 10 * bc + bc / 16) begin fails++; $display("FAIL b2b_spacing got %0d want %0d+-%0d", gap, 10 * bc, bc / 16); end
  endtask

  task automatic test_reset_mid;
    int bc, n0;
    logic [7:0] b;
    baud_set = 3'd4;
    bc = bit_clks(3'd4);
    b = 8'h5A;
    n0 = rx_cnt;
    drive_bit(1'b0, bc);
    for (int i = 0; i < 4; i++) drive_bit(b[i], bc);
    drive_bit(b[4], bc / 2);
    rst_n = 1'b0;
    rs232_rx = 1'b1;
    #1;
    tests++; if (data !== 8'h00 || rx_done !== 1'b0 || frame_err !== 1'b0 || uart_state !== 1'b0) begin fails++; $display("FAIL rstmid_outputs got d=%h r=%b f=%b s=%b want 00 0 0 0", data, rx_done, frame_err, uart_state); end
    repeat (10) @(negedge clk);
    rst_n = 1'b1;
    drive_bit(1'b1, 12 * bc);
    tests++; if (rx_cnt - n0 !== 0) begin fails++; $display("FAIL rstmid_rx_done got %0d want 0", rx_cnt - n0); end
    send_frame(8'hC3, bc, 1'b1);
    wait_rx(n0 + 1, 2 * bc);
    tests++; if (data !== 8'hC3 || rx_cnt - n0 !== 1) begin fails++; $display("FAIL rstmid_next got %h/%0d want c3/1", data, rx_cnt - n0); end
  endtask

  // Random bytes at random rates; baud_set is scrambled after each start edge and must be ignored.
  task automatic test_random;
    int bc, n0;
    logic [2:0] sel;
    logic [7:0] b;
    for (int k = 0; k < 6; k++) begin
      sel = 3'($urandom_range(3, 4));
      b = 8'($urandom);
      baud_set = sel;
      bc = bit_clks(sel);
      n0 = rx_cnt;
      drive_bit(1'b1, $urandom_range(1, bc));
      drive_bit(1'b0, 4);
      baud_set = 3'($urandom_range(0, 7));
      drive_bit(1'b0, bc - 4);
      for (int i = 0; i < 8; i++) drive_bit(b[i], bc);
      drive_bit(1'b1, bc);
      wait_rx(n0 + 1, 2 * bc);
      tests++; if (rx_cnt - n0 !== 1 || data !== b) begin fails++; $display("FAIL random_%0d got %h/%0d want %h/1 (sel %0d)", k, data, rx_cnt - n0, b, sel); end
    end
  endtask

  task automatic test_pulse_shape;
    tests++; if (overlap !== 0) begin fails++; $display("FAIL pulse_overlap got %0d want 0", overlap); end
    tests++; if (wide !== 0) begin fails++; $display("FAIL pulse_width got %0d wide pulses want 0", wide); end
  endtask

  initial begin
    @(negedge clk);
    test_reset;
    test_loopback;
    test_glitch;
    test_frame_err;
    test_back_to_back;
    test_reset_mid;
    test_random;
    test_pulse_shape;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
